sa_skew_feeder: RTL and testbench

- Sits directly upstream of the systolic array.
- Accepts one activation vector and one weight vector per handshake beat, applies the diagonal skew (lane i delayed i cycles), and drives the array's data, weight and control inputs (sa_load, sa_clear, sa_carry_en) for one output-stationary tile of K beats.
- Sequences each tile as clear, feed, flush, drain, done.

---
 rtl/sa_skew_feeder.sv | 165 ++++++++++++++++
 tb/tb_sa_skew_feeder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_skew_feeder.sv
// rtl/sa_skew_feeder.sv - diagonal skew feeder and tile sequencer for the systolic array
module sa_skew_feeder #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] k_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ib_in       [SIZE],
    input  logic [WIDTH-1:0] wb_in       [SIZE],
    output logic [WIDTH-1:0] ib_data_out [SIZE],
    output logic [WIDTH-1:0] wb_data_out [SIZE],
    output logic             sa_load,
    output logic             sa_clear,
    output logic [SIZE-1:0]  sa_carry_en,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Flush must let the last beat cross the skew and reach the far corner PE.
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(2 * SIZE - 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(SIZE - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] k_len_q, k_len_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [CNT_W-1:0] beat_nxt;
    logic             load_q, load_d;
    logic             accept;

    // A beat only enters the skew chains on a FEED-state handshake.
    assign accept   = (state_q == ST_FEED) && in_valid;
    assign beat_nxt = beat_cnt_q + CNT_W'(1);
    assign sa_load  = load_q;

    // Tile sequencer: next state, counters and the unregistered control outputs.
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        beat_cnt_d  = beat_cnt_q;
        phase_cnt_d = phase_cnt_q;
        in_ready    = 1'b0;
        sa_clear    = 1'b0;
        sa_carry_en = '0;
        busy        = (state_q != ST_IDLE);
        done        = 1'b0;
        load_d      = (state_q == ST_FEED) || (state_q == ST_FLUSH);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_len_d     = k_len;
                    beat_cnt_d  = '0;
                    phase_cnt_d = '0;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                sa_clear = 1'b1;
                state_d  = (k_len_q != '0) ? ST_FEED : ST_DRAIN;
            end
            ST_FEED: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    beat_cnt_d = beat_nxt;
                    if (beat_nxt == k_len_q) begin
                        phase_cnt_d = '0;
                        state_d     = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (phase_cnt_q == FLUSH_LAST) begin
                    phase_cnt_d = '0;
                    state_d     = ST_DRAIN;
                end else begin
                    phase_cnt_d = phase_cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                sa_carry_en = '1;
                if (phase_cnt_q == DRAIN_LAST) begin
                    phase_cnt_d = '0;
                    state_d     = ST_DONE;
                end else begin
                    phase_cnt_d = phase_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state; reset aborts any tile in flight without draining.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            beat_cnt_q  <= '0;
            phase_cnt_q <= '0;
            load_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            beat_cnt_q  <= beat_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            load_q      <= load_d;
        end
    end

    // Lane i is an (i+1)-deep shift chain so lane i lags lane 0 by i cycles.
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [WIDTH-1:0] ib_sr_q [i+1];
        logic [WIDTH-1:0] ib_sr_d [i+1];
        logic [WIDTH-1:0] wb_sr_q [i+1];
        logic [WIDTH-1:0] wb_sr_d [i+1];

        // Chain input is zero on any cycle without a handshake, keeping lanes aligned.
        always_comb begin
            ib_sr_d[0] = accept ? ib_in[i] : '0;
            wb_sr_d[0] = accept ? wb_in[i] : '0;
            for (int k = 1; k <= i; k++) begin
                ib_sr_d[k] = ib_sr_q[k-1];
                wb_sr_d[k] = wb_sr_q[k-1];
            end
        end

        // Chains shift every cycle regardless of sequencer state.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int k = 0; k <= i; k++) begin
                    ib_sr_q[k] <= '0;
                    wb_sr_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k <= i; k++) begin
                    ib_sr_q[k] <= ib_sr_d[k];
                    wb_sr_q[k] <= wb_sr_d[k];
                end
            end
        end

        assign ib_data_out[i] = ib_sr_q[i];
        assign wb_data_out[i] = wb_sr_q[i];
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb/tb_sa_skew_feeder.sv - self-checking bench for sa_skew_feeder
module tb_sa_skew_feeder;

    localparam int WIDTH     = 8;
    localparam int SIZE      = 4;
    localparam int CNT_W     = 16;
    localparam int FLUSH_CYC = 2 * SIZE - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [CNT_W-1:0] k_len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] ib_in       [SIZE];
    logic [WIDTH-1:0] wb_in       [SIZE];
    logic [WIDTH-1:0] ib_data_out [SIZE];
    logic [WIDTH-1:0] wb_data_out [SIZE];
    logic             sa_load;
    logic             sa_clear;
    logic [SIZE-1:0]  sa_carry_en;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    sa_skew_feeder #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .k_len       (k_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ib_in       (ib_in),
        .wb_in       (wb_in),
        .ib_data_out (ib_data_out),
        .wb_data_out (wb_data_out),
        .sa_load     (sa_load),
        .sa_clear    (sa_clear),
        .sa_carry_en (sa_carry_en),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        int k;
        int mode;
        bit hold;
        int total;
    } vec_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    bit  chk_en  = 1'b0;
    bit  e_ready, e_clear, e_busy, e_done, e_carry, e_ff, e_acc, load_prev;
    int  busy_seen, done_seen;

    logic [WIDTH-1:0] sb_ib [SIZE][$];
    logic [WIDTH-1:0] sb_wb [SIZE][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic sb_reset();
        for (int i = 0; i < SIZE; i++) begin
            sb_ib[i].delete();
            sb_wb[i].delete();
            for (int k = 0; k <= i; k++) begin
                sb_ib[i].push_back(8'h00);
                sb_wb[i].push_back(8'h00);
            end
        end
        load_prev = 1'b0;
    endtask

    // 0 idle, 1 clear, 2 feed, 3 flush, 4 drain, 5 done
    task automatic set_exp(input int st);
        e_ready = (st == 2);
        e_clear = (st == 1);
        e_busy  = (st != 0);
        e_done  = (st == 5);
        e_carry = (st == 4);
        e_ff    = (st == 2) || (st == 3);
        e_acc   = 1'b0;
    endtask

    task automatic junk();
        for (int i = 0; i < SIZE; i++) begin
            ib_in[i] = WIDTH'($urandom);
            wb_in[i] = WIDTH'($urandom);
        end
    endtask

    task automatic drive_data(input int b);
        for (int i = 0; i < SIZE; i++) begin
            ib_in[i] = WIDTH'(b * 16 + i + 1);
            wb_in[i] = WIDTH'(b * 16 + i + 5);
        end
    endtask

    task automatic tick();
        logic [WIDTH-1:0] ei;
        logic [WIDTH-1:0] ew;
        logic [SIZE-1:0]  ec;
        @(negedge clk);
        if (chk_en) begin
            ec = e_carry ? {SIZE{1'b1}} : {SIZE{1'b0}};
            check("in_ready", 32'(in_ready), 32'(e_ready));
            check("sa_clear", 32'(sa_clear), 32'(e_clear));
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(e_done));
            check("sa_load", 32'(sa_load), 32'(load_prev));
            check("sa_carry_en", 32'(sa_carry_en), 32'(ec));
            for (int i = 0; i < SIZE; i++) begin
                ei = sb_ib[i].pop_front();
                ew = sb_wb[i].pop_front();
                check($sformatf("ib_lane%0d", i), 32'(ib_data_out[i]), 32'(ei));
                check($sformatf("wb_lane%0d", i), 32'(wb_data_out[i]), 32'(ew));
            end
            busy_seen += (busy === 1'b1) ? 1 : 0;
            done_seen += (done === 1'b1) ? 1 : 0;
            for (int i = 0; i < SIZE; i++) begin
                sb_ib[i].push_back(e_acc ? ib_in[i] : 8'h00);
                sb_wb[i].push_back(e_acc ? wb_in[i] : 8'h00);
            end
            load_prev = e_ff;
            if (!reset_n) sb_reset();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0: always valid, 1: valid toggles 1,0,1,..., 2: random valid and data
    task automatic run_tile(input int k, input int mode, input bit hold, output int fc);
        int acc_n;
        bit v;
        acc_n     = 0;
        fc        = 0;
        busy_seen = 0;
        done_seen = 0;
        set_exp(0);
        start    = 1'b1;
        k_len    = CNT_W'(k);
        in_valid = 1'($urandom_range(0, 1));
        junk();
        tick();
        set_exp(1);
        start    = hold;
        k_len    = CNT_W'($urandom);
        in_valid = 1'b1;
        junk();
        tick();
        while (acc_n < k && fc < 200) begin
            set_exp(2);
            case (mode)
                0:       v = 1'b1;
                1:       v = (fc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            if (v && mode != 2) drive_data(acc_n);
            else junk();
            e_acc = v;
            tick();
            acc_n += int'(v);
            fc++;
        end
        if (acc_n < k) begin
            n_tests++;
            n_fail++;
            $display("FAIL feed_timeout accepts=%0d required=%0d", acc_n, k);
        end
        if (k != 0) begin
            for (int c = 0; c < FLUSH_CYC; c++) begin
                set_exp(3);
                in_valid = 1'($urandom_range(0, 1));
                junk();
                tick();
            end
        end
        for (int c = 0; c < SIZE; c++) begin
            set_exp(4);
            in_valid = 1'($urandom_range(0, 1));
            junk();
            tick();
        end
        set_exp(5);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    vec_t tbl[6];
    int   fc;

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{k: 1, mode: 0, hold: 1'b0, total: 14};
        tbl[1] = '{k: 3, mode: 1, hold: 1'b0, total: 18};
        tbl[2] = '{k: 0, mode: 0, hold: 1'b0, total: 6};
        tbl[3] = '{k: 2, mode: 0, hold: 1'b1, total: 15};
        tbl[4] = '{k: 2, mode: 0, hold: 1'b0, total: 15};
        tbl[5] = '{k: 4, mode: 1, hold: 1'b0, total: 20};

        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        k_len    = '0;
        junk();
        repeat (3) @(posedge clk);
        #1;
        sb_reset();
        chk_en  = 1'b1;
        reset_n = 1'b1;
        set_exp(0);
        tick();
        tick();

        for (int t = 0; t < 6; t++) begin
            run_tile(tbl[t].k, tbl[t].mode, tbl[t].hold, fc);
            check($sformatf("busy_cycles_row%0d", t), 32'(busy_seen), 32'(tbl[t].total));
            check($sformatf("done_pulses_row%0d", t), 32'(done_seen), 32'd1);
        end

        // Reset in the middle of FEED after two of five beats.
        set_exp(0);
        start = 1'b1;
        k_len = CNT_W'(5);
        tick();
        set_exp(1);
        start = 1'b0;
        tick();
        for (int b = 0; b < 2; b++) begin
            set_exp(2);
            in_valid = 1'b1;
            drive_data(b + 8);
            e_acc = 1'b1;
            tick();
        end
        set_exp(2);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        reset_n = 1'b1;
        set_exp(0);
        tick();
        tick();
        run_tile(2, 0, 1'b0, fc);
        check("busy_cycles_after_reset", 32'(busy_seen), 32'd15);
        check("done_pulses_after_reset", 32'(done_seen), 32'd1);

        // Random tiles.
        for (int r = 0; r < 6; r++) begin
            run_tile(int'($urandom_range(1, 20)), 2, 1'b0, fc);
            check($sformatf("busy_cycles_rand%0d", r), 32'(busy_seen), 32'(1 + fc + FLUSH_CYC + SIZE + 1));
            check($sformatf("done_pulses_rand%0d", r), 32'(done_seen), 32'd1);
        end

        set_exp(0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
